// File: rtl/sha256_msg_padder_if.sv
// Word stream into the SHA-256 padder: 32-bit big-endian message words with
// a last-word marker and a byte count for the final word.
interface sha256_msg_padder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_bytes;

    modport master (output in_valid, in_data, in_last, in_bytes, input in_ready);
    modport slave  (input in_valid, in_data, in_last, in_bytes, output in_ready);
endinterface

// File: rtl/sha256_msg_padder.sv
// Builds padded 512-bit SHA-256 blocks from a word stream, drives the core's
// init/next handshake block by block and registers the final digest.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sha256_msg_padder_if.slave   s,
    output logic                 core_init,
    output logic                 core_next,
    output logic [511:0]         core_block,
    input  logic                 core_ready,
    input  logic                 core_digest_valid,
    input  logic [255:0]         core_digest,
    output logic [255:0]         digest,
    output logic                 digest_valid,
    output logic                 busy
);
    typedef enum logic [2:0] {COLLECT, PAD, ISSUE, WAIT_ACK, WAIT, DONE} state_t;

    state_t           state_reg;
    state_t           ret_reg;
    logic [31:0]      buf_mem [16];
    logic [4:0]       wptr_reg;
    logic [LEN_W-1:0] len_reg;
    logic             cont_reg;     // set once a block of this message went out
    logic             marker_reg;   // 0x80 marker still owed after a full final word
    logic             rdy_en_reg;   // keeps in_ready low in the cycle right after reset

    logic             accept;
    logic [LEN_W-1:0] len_inc;
    logic [31:0]      final_word;
    logic [63:0]      len_field;

    assign s.in_ready = rdy_en_reg && (state_reg == COLLECT) && !wptr_reg[4];
    assign accept     = s.in_valid && s.in_ready;
    assign len_field  = 64'(len_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_block
            assign core_block[511-32*gi -: 32] = buf_mem[gi];
        end
    endgenerate

    always_comb begin
        len_inc = LEN_W'(32);
        if (s.in_last && s.in_bytes != 2'd0)
            len_inc = LEN_W'({s.in_bytes, 3'b000});
        case (s.in_bytes)
            2'd1:    final_word = {s.in_data[31:24], 8'h80, 16'h0000};
            2'd2:    final_word = {s.in_data[31:16], 8'h80, 8'h00};
            2'd3:    final_word = {s.in_data[31:8], 8'h80};
            default: final_word = s.in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= COLLECT;
            ret_reg      <= COLLECT;
            wptr_reg     <= '0;
            len_reg      <= '0;
            cont_reg     <= 1'b0;
            marker_reg   <= 1'b0;
            rdy_en_reg   <= 1'b0;
            core_init    <= 1'b0;
            core_next    <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < 16; i++) buf_mem[i] <= '0;
        end else begin
            rdy_en_reg <= 1'b1;
            core_init  <= 1'b0;
            core_next  <= 1'b0;
            case (state_reg)
                COLLECT: if (accept) begin
                    len_reg  <= len_reg + len_inc;
                    busy     <= 1'b1;
                    if (!busy) digest_valid <= 1'b0;
                    wptr_reg <= wptr_reg + 5'd1;
                    if (!s.in_last) begin
                        buf_mem[wptr_reg[3:0]] <= s.in_data;
                        if (wptr_reg == 5'd15) begin
                            state_reg <= ISSUE;
                            ret_reg   <= COLLECT;
                        end
                    end else begin
                        buf_mem[wptr_reg[3:0]] <= final_word;
                        marker_reg <= (s.in_bytes == 2'd0);
                        state_reg  <= PAD;
                    end
                end
                PAD: begin
                    // A full buffer goes out first; padding resumes at word 0.
                    if (wptr_reg[4]) begin
                        state_reg <= ISSUE;
                        ret_reg   <= PAD;
                    end else if (marker_reg) begin
                        buf_mem[wptr_reg[3:0]] <= 32'h8000_0000;
                        wptr_reg   <= wptr_reg + 5'd1;
                        marker_reg <= 1'b0;
                    end else if (wptr_reg == 5'd14) begin
                        buf_mem[14] <= len_field[63:32];
                        buf_mem[15] <= len_field[31:0];
                        wptr_reg    <= 5'd16;
                        state_reg   <= ISSUE;
                        ret_reg     <= DONE;
                    end else begin
                        buf_mem[wptr_reg[3:0]] <= 32'h0;
                        wptr_reg <= wptr_reg + 5'd1;
                    end
                end
                ISSUE: if (core_ready) begin
                    core_init <= !cont_reg;
                    core_next <= cont_reg;
                    cont_reg  <= 1'b1;
                    state_reg <= WAIT_ACK;
                end
                WAIT_ACK: state_reg <= WAIT;
                WAIT: if (core_ready && core_digest_valid) begin
                    wptr_reg  <= '0;
                    state_reg <= ret_reg;
                end
                DONE: begin
                    digest       <= core_digest;
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                    len_reg      <= '0;
                    cont_reg     <= 1'b0;
                    state_reg    <= COLLECT;
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with a behavioural SHA-256 core
// (66-cycle latency) attached to the core handshake.
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus();
    logic         core_init, core_next, core_ready, core_digest_valid;
    logic [511:0] core_block;
    logic [255:0] core_digest, digest;
    logic         digest_valid, busy;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset(reset), .s(bus),
        .core_init(core_init), .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_digest_valid(core_digest_valid),
        .core_digest(core_digest), .digest(digest),
        .digest_valid(digest_valid), .busy(busy)
    );

    localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    int nvec = 0;
    int nerr = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Behavioural core: captures the block on a pulse, goes busy for 66 cycles.
    logic [255:0] h_state = IV;
    logic [511:0] cur_blk = '0;
    logic         core_idle = 1'b1;
    logic         core_dv_m = 1'b0;
    logic         stall = 1'b0;
    logic         skip_stab = 1'b0;
    int           core_cnt = 0;
    int           proto_err = 0;
    int           init_cnt = 0;
    int           next_cnt = 0;
    logic [511:0] blk_q [$];
    logic         init_q [$];

    assign core_ready        = core_idle && !stall;
    assign core_digest_valid = core_dv_m;
    assign core_digest       = h_state;

    always @(posedge clk) begin
        if (reset) skip_stab <= 1'b1;
        if (core_init || core_next) begin
            if (!core_ready || (core_init && core_next)) proto_err <= proto_err + 1;
            blk_q.push_back(core_block);
            init_q.push_back(core_init);
            init_cnt  <= init_cnt + (core_init ? 1 : 0);
            next_cnt  <= next_cnt + (core_next ? 1 : 0);
            h_state   <= sha_compress(core_init ? IV : h_state, core_block);
            cur_blk   <= core_block;
            core_idle <= 1'b0;
            core_dv_m <= 1'b0;
            core_cnt  <= 65;
            skip_stab <= 1'b0;
        end else if (!core_idle) begin
            if (core_block !== cur_blk && !skip_stab && !reset) proto_err <= proto_err + 1;
            if (core_cnt <= 1) begin
                core_idle <= 1'b1;
                core_dv_m <= 1'b1;
            end
            core_cnt <= core_cnt - 1;
        end
    end

    logic [31:0] msg_q [$];
    int          stall_q [$];

    function automatic logic [511:0] put_word(input logic [511:0] b, input int i, input logic [31:0] w);
        b[511-32*i -: 32] = w;
        return b;
    endfunction

    function automatic logic [511:0] get_blk(input int i);
        if (i < blk_q.size()) return blk_q[i];
        return 'x;
    endfunction

    function automatic logic get_init(input int i);
        if (i < init_q.size()) return init_q[i];
        return 1'bx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_msg(input logic [1:0] last_bytes);
        int t;
        stall_q.delete();
        for (int i = 0; i < msg_q.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = msg_q[i];
            bus.in_last  = (i == msg_q.size() - 1);
            bus.in_bytes = (i == msg_q.size() - 1) ? last_bytes : 2'd0;
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                nvec++; nerr++;
                $display("FAIL send_word%0d: in_ready stuck low for %0d cycles, required 1", i, t);
            end
            stall_q.push_back(t);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 2'd0;
    endtask

    task automatic wait_digest();
        int t = 0;
        while (digest_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        nvec++;
        if (digest_valid !== 1'b1) begin
            nerr++;
            $display("FAIL digest_timeout: digest_valid=%b after %0d cycles, required 1", digest_valid, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        nvec++;
        if ({core_init, core_next, digest_valid, busy, bus.in_ready} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b, required 00000", {core_init, core_next, digest_valid, busy, bus.in_ready});
        end
        nvec++;
        if (core_block !== 512'h0 || digest !== 256'h0) begin
            nerr++;
            $display("FAIL reset_data: block=%h digest=%h, required 0", core_block, digest);
        end
        reset = 1'b0;
        tick(1);
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_abc();
        logic [511:0] exp_b;
        blk_q.delete(); init_q.delete();
        msg_q = '{32'h61626300};
        send_msg(2'd3);
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL abc_busy: busy=%b, required 1", busy); end
        wait_digest();
        exp_b = {32'h61626380, 448'h0, 32'h00000018};
        nvec++;
        if (blk_q.size() !== 1 || get_init(0) !== 1'b1) begin
            nerr++;
            $display("FAIL abc_pulses: blocks=%0d init=%b, required 1 block with init", blk_q.size(), get_init(0));
        end
        nvec++;
        if (get_blk(0) !== exp_b) begin nerr++; $display("FAIL abc_block: got %h required %h", get_blk(0), exp_b); end
        nvec++;
        if (digest !== ABC) begin nerr++; $display("FAIL abc_digest: got %h required %h", digest, ABC); end
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL abc_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_two_block();
        logic [511:0] exp1, exp2;
        blk_q.delete(); init_q.delete();
        msg_q = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
                  32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        send_msg(2'd0);
        wait_digest();
        exp1 = '0;
        for (int i = 0; i < 14; i++) exp1 = put_word(exp1, i, msg_q[i]);
        exp1 = put_word(exp1, 14, 32'h80000000);
        exp2 = {480'h0, 32'h000001C0};
        nvec++;
        if (blk_q.size() !== 2 || get_init(0) !== 1'b1 || get_init(1) !== 1'b0) begin
            nerr++;
            $display("FAIL two_pulses: blocks=%0d init0=%b init1=%b, required 2 blocks init then next",
                     blk_q.size(), get_init(0), get_init(1));
        end
        nvec++;
        if (get_blk(0) !== exp1) begin nerr++; $display("FAIL two_block1: got %h required %h", get_blk(0), exp1); end
        nvec++;
        if (get_blk(1) !== exp2) begin nerr++; $display("FAIL two_block2: got %h required %h", get_blk(1), exp2); end
        nvec++;
        if (digest !== TWO) begin nerr++; $display("FAIL two_digest: got %h required %h", digest, TWO); end
    endtask

    task automatic test_55_64();
        logic [511:0] exp1, exp2;
        blk_q.delete(); init_q.delete();
        msg_q.delete();
        for (int i = 0; i < 13; i++) msg_q.push_back(32'h11111111 * (i + 1));
        msg_q.push_back(32'hAABBCCDD);
        send_msg(2'd3);
        wait_digest();
        exp1 = '0;
        for (int i = 0; i < 13; i++) exp1 = put_word(exp1, i, msg_q[i]);
        exp1 = put_word(exp1, 13, 32'hAABBCC80);
        exp1 = put_word(exp1, 15, 32'h000001B8);
        nvec++;
        if (blk_q.size() !== 1) begin nerr++; $display("FAIL b55_count: blocks=%0d, required 1", blk_q.size()); end
        nvec++;
        if (get_blk(0) !== exp1) begin nerr++; $display("FAIL b55_block: got %h required %h", get_blk(0), exp1); end

        blk_q.delete(); init_q.delete();
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(32'hC0DE0000 + i);
        send_msg(2'd0);
        wait_digest();
        exp1 = '0;
        for (int i = 0; i < 16; i++) exp1 = put_word(exp1, i, msg_q[i]);
        exp2 = {32'h80000000, 448'h0, 32'h00000200};
        nvec++;
        if (blk_q.size() !== 2 || get_init(1) !== 1'b0) begin
            nerr++;
            $display("FAIL b64_pulses: blocks=%0d init1=%b, required 2 blocks second next", blk_q.size(), get_init(1));
        end
        nvec++;
        if (get_blk(0) !== exp1) begin nerr++; $display("FAIL b64_block1: got %h required %h", get_blk(0), exp1); end
        nvec++;
        if (get_blk(1) !== exp2) begin nerr++; $display("FAIL b64_block2: got %h required %h", get_blk(1), exp2); end
    endtask

    task automatic test_back_pressure();
        logic [511:0] exp2;
        blk_q.delete(); init_q.delete();
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(32'hA5000000 | i);
        send_msg(2'd0);
        nvec++;
        if (stall_q[15] !== 0) begin nerr++; $display("FAIL bp_word15: stalled %0d cycles, required 0", stall_q[15]); end
        nvec++;
        if (stall_q[16] < 66) begin nerr++; $display("FAIL bp_word16: stalled %0d cycles, required >= 66", stall_q[16]); end
        wait_digest();
        exp2 = '0;
        for (int i = 0; i < 4; i++) exp2 = put_word(exp2, i, msg_q[16 + i]);
        exp2 = put_word(exp2, 4, 32'h80000000);
        exp2 = put_word(exp2, 15, 32'h00000280);
        nvec++;
        if (get_blk(1) !== exp2) begin nerr++; $display("FAIL bp_block2: got %h required %h", get_blk(1), exp2); end
    endtask

    task automatic test_issue_stall();
        int p0;
        blk_q.delete(); init_q.delete();
        stall = 1'b1;
        msg_q = '{32'h61626300};
        send_msg(2'd3);
        p0 = init_cnt + next_cnt;
        tick(10);
        nvec++;
        if (init_cnt + next_cnt !== p0) begin
            nerr++;
            $display("FAIL stall_nopulse: pulses=%0d, required %0d", init_cnt + next_cnt, p0);
        end
        stall = 1'b0;
        wait_digest();
        nvec++;
        if (init_cnt + next_cnt !== p0 + 1) begin
            nerr++;
            $display("FAIL stall_pulse: pulses=%0d, required %0d", init_cnt + next_cnt, p0 + 1);
        end
        nvec++;
        if (digest !== ABC) begin nerr++; $display("FAIL stall_digest: got %h required %h", digest, ABC); end
    endtask

    task automatic test_reset_mid();
        int p0, i0, n0, t;
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(32'h5A5A0000 + i);
        p0 = init_cnt + next_cnt;
        send_msg(2'd0);
        t = 0;
        while (init_cnt + next_cnt == p0 && t < 500) begin @(negedge clk); t++; end
        tick(5);
        reset = 1'b1;
        tick(1);
        nvec++;
        if ({core_init, core_next, digest_valid, busy, bus.in_ready} !== 5'b0) begin
            nerr++;
            $display("FAIL midrst_flags: got %b, required 00000", {core_init, core_next, digest_valid, busy, bus.in_ready});
        end
        nvec++;
        if (core_block !== 512'h0 || digest !== 256'h0) begin
            nerr++;
            $display("FAIL midrst_data: block=%h digest=%h, required 0", core_block, digest);
        end
        reset = 1'b0;
        tick(1);
        blk_q.delete(); init_q.delete();
        i0 = init_cnt; n0 = next_cnt;
        msg_q = '{32'h61626300};
        send_msg(2'd3);
        wait_digest();
        nvec++;
        if (init_cnt !== i0 + 1 || next_cnt !== n0) begin
            nerr++;
            $display("FAIL midrst_init: init+%0d next+%0d, required init+1 next+0", init_cnt - i0, next_cnt - n0);
        end
        nvec++;
        if (digest !== ABC) begin nerr++; $display("FAIL midrst_digest: got %h required %h", digest, ABC); end
    endtask

    task automatic test_back_to_back();
        int i0, n0;
        msg_q = '{32'h61626300};
        send_msg(2'd3);
        wait_digest();
        nvec++;
        if (digest !== ABC) begin nerr++; $display("FAIL b2b_first: got %h required %h", digest, ABC); end
        i0 = init_cnt; n0 = next_cnt;
        send_msg(2'd3);
        nvec++;
        if (digest_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drop: digest_valid=%b, required 0", digest_valid); end
        wait_digest();
        nvec++;
        if (digest !== ABC) begin nerr++; $display("FAIL b2b_second: got %h required %h", digest, ABC); end
        nvec++;
        if (init_cnt !== i0 + 1 || next_cnt !== n0) begin
            nerr++;
            $display("FAIL b2b_init: init+%0d next+%0d, required init+1 next+0", init_cnt - i0, next_cnt - n0);
        end
    endtask

    task automatic test_protocol();
        nvec++;
        if (proto_err !== 0) begin
            nerr++;
            $display("FAIL protocol: %0d handshake or block-hold violations, required 0", proto_err);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 2'd0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_two_block();
        test_55_64();
        test_back_pressure();
        test_issue_stall();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 compression core.
- Accepts a byte-granular message as a stream of 32-bit big-endian words.
- Assembles 512-bit blocks and applies FIPS 180-4 padding: 0x80 marker, zero fill, and 64-bit bit-length.
- Sequences the core's init/next/ready/digest_valid handshake per block, then registers and presents the final 256-bit digest.

Parameters:
- LEN_W, 64: width of the internal message bit-length counter (8..64). It is zero-extended into the 64-bit length field and wraps modulo 2^LEN_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  padder accepts a word this cycle
- in_data  input  32  message word; first byte in [31:24]
- in_last  input  1  word is the final word of the message
- in_bytes  input  2  valid bytes in the final word: 0=4, 1..3=count. Ignored when in_last=0.
- core_init  output  1  one-cycle pulse, first block of a message
- core_next  output  1  one-cycle pulse, subsequent blocks
- core_block  output  512  block to core; word 0 in [511:480]
- core_ready  input  1  core idle
- core_digest_valid  input  1  core finished last block
- core_digest  input  256  core hash state
- digest  output  256  final message digest
- digest_valid  output  1  digest holds a completed hash
- busy  output  1  a message is in progress (between first word accepted and digest_valid)

Behaviour:
- Reset: all outputs 0; word pointer, length counter and first-block flag cleared; state COLLECT. The core is not reset by this block; the next issue still waits for core_ready=1.
- Buffer: 16x32 word array with 5-bit pointer wptr (0..16). core_block is driven directly from the array and held stable from the pulse until the block completes.
- Transfer: a word is accepted when in_valid && in_ready. Each accepted word adds 32 to the length counter, or 8*in_bytes when it is a final word with in_bytes≠0.
- Accepting the first word of a new message clears digest_valid in the same edge.
- Messages are at least 1 byte; empty messages are unsupported.
- States:
  - COLLECT: in_ready=1 while wptr<16. Non-final word → store, wptr++. When wptr reaches 16 → ISSUE (ret=COLLECT).
  - COLLECT, final word with n<4 bytes: store data bytes, byte n=0x80, remaining bytes 0, wptr++ → PAD.
  - COLLECT, final word with n=4: store word, wptr++; marker owed → PAD.
  - PAD (in_ready=0): if marker owed, write 0x80000000 at wptr and wptr++.
    - Then zero-fill one word per cycle up to wptr=14.
    - Words 14,15 ← {zero-ext length}[63:32], [31:0] → ISSUE (ret=DONE).
    - If marker placement leaves wptr>14: zero-fill to 16 → ISSUE (ret=PAD), then restart at wptr=0 with zero fill.
  - ISSUE: wait for core_ready=1. Pulse core_init if first-block flag is set, else core_next, for exactly one cycle. Clear first-block flag → WAIT_ACK.
  - WAIT_ACK: one cycle (core leaves idle) → WAIT.
  - WAIT: when core_ready && core_digest_valid: wptr←0. Go to ret; if ret=DONE → DONE.
  - DONE: digest←core_digest, digest_valid←1; length cleared, first-block flag set → COLLECT.
- No core pulse is ever issued while core_ready=0. core_init and core_next are never high together.
- in_ready is 0 in all states except COLLECT.
- Per-block latency: pulse to digest_valid = 66 cycles (core). Input back-pressure lasts for the whole block.
- Mid-message reset: message discarded. The first pulse after reset is core_init.

Test Plan:
- "abc": one word 0x61626300, in_last=1, in_bytes=3 → one core_init. Block word0=0x61626380, words1–14=0, word15=0x00000018. digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid=1.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as 14 full words, last with in_bytes=0 → core_init then core_next. Second block words 0–13 zero except word0=0x80000000 absent (marker in block 1 word14), length word15=0x000001C0. digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 55-byte message (final in_bytes=3) → exactly one block, 0x80 in byte 55, length 0x1B8. A 64-byte message → two blocks, second block starts 0x80000000.
- Back-pressure: hold in_valid=1 through a 20-word message → in_ready=0 from word 16 until the block completes (≥66 cycles). Stall core_ready=0 for 10 cycles in ISSUE → no pulse until it rises.
- Reset asserted during WAIT of a two-block message → all outputs 0 next cycle. A new "abc" then yields core_init and the correct digest.
- Back-to-back "abc" messages → digest_valid drops on the second message's first accepted word. The second digest is identical and uses core_init.
